// File: rtl/bk_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// bk_serial_add_ctrl
//   Byte-serial wide adder built around a single 8-bit Brent-Kung adder.
//   Operands are accepted through a valid/ready handshake, then added one
//   byte per clock, LSB byte first. The carry between bytes is held in a
//   register. The result is offered through a second valid/ready handshake.
//
// Parameters
//   NBYTES    operand width in bytes (W = 8*NBYTES), legal range 2..16
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand request
//   in_ready   controller can accept operands (IDLE)
//   a, b       W-bit operands, sampled only at the accepting edge
//   cin        carry into byte 0
//   sub        (BK_SUB_EN only) 1 = compute a - b; cin is ignored
//   abort      synchronous cancel; blocks acceptance, drops RUN/DONE work
//   busy       an operation is in progress (RUN or DONE)
//   out_valid  result available (DONE)
//   out_ready  consumer accepts result
//   sum        W-bit result, meaningful only while out_valid=1
//   cout       carry out of the top byte (for sub: 1 = no borrow)
//
// Build option
//   BK_SUB_EN  adds the `sub` port and two's-complement subtraction.
// ---------------------------------------------------------------------------

module Brent_kung_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);
    logic [7:0] g;
    logic [7:0] p;
    // Group generate/propagate for spans (i:0), index i
    logic [7:0] gg;
    logic [7:0] gp;
    logic [8:0] c;

    // Intermediate spans of the up-sweep
    logic g10, p10, g32, p32, g54, p54, g76, p76;
    logic g30, p30, g74, p74;

    always_comb begin
        g = a & b;
        p = a ^ b;

        // Up-sweep
        g10 = g[1] | (p[1] & g[0]);  p10 = p[1] & p[0];
        g32 = g[3] | (p[3] & g[2]);  p32 = p[3] & p[2];
        g54 = g[5] | (p[5] & g[4]);  p54 = p[5] & p[4];
        g76 = g[7] | (p[7] & g[6]);  p76 = p[7] & p[6];

        g30 = g32 | (p32 & g10);     p30 = p32 & p10;
        g74 = g76 | (p76 & g54);     p74 = p76 & p54;

        gg = '0;
        gp = '0;
        gg[0] = g[0];                gp[0] = p[0];
        gg[1] = g10;                 gp[1] = p10;
        gg[3] = g30;                 gp[3] = p30;
        gg[7] = g74 | (p74 & g30);   gp[7] = p74 & p30;

        // Down-sweep
        gg[5] = g54 | (p54 & g30);   gp[5] = p54 & p30;
        gg[2] = g[2] | (p[2] & g10); gp[2] = p[2] & p10;
        gg[4] = g[4] | (p[4] & g30); gp[4] = p[4] & p30;
        gg[6] = g[6] | (p[6] & gg[5]); gp[6] = p[6] & gp[5];

        c[0] = cin;
        for (int unsigned i = 0; i < 8; i++) begin
            c[i+1] = gg[i] | (gp[i] & cin);
        end

        s    = p ^ c[7:0];
        cout = c[8];
    end
endmodule

module bk_serial_add_ctrl #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    input  logic                cin,
`ifdef BK_SUB_EN
    input  logic                sub,
`endif
    input  logic                abort,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] sum,
    output logic                cout
);
    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned CW = $clog2(NBYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    a_sh, b_sh;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            last;
    logic [7:0]      add_s;
    logic            add_cout;
    logic [W-1:0]    b_load;
    logic            carry_load;

    Brent_kung_8bit u_bk (
        .a    (a_sh[7:0]),
        .b    (b_sh[7:0]),
        .cin  (carry),
        .s    (add_s),
        .cout (add_cout)
    );

    assign accept = in_valid && in_ready && !abort;
    assign last   = (cnt == CW'(NBYTES - 1));

`ifdef BK_SUB_EN
    // Subtraction as a + ~b + 1
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)               state_nxt = RUN;
            RUN:  if (abort)                state_nxt = IDLE;
                  else if (last)            state_nxt = DONE;
            DONE: if (abort || out_ready)   state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // Outputs; in_ready is gated by rst_n so it stays low throughout reset
    always_comb begin
        in_ready  = (state == IDLE) && rst_n;
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (!abort) begin
                        sum   <= {add_s, sum[W-1:8]};
                        a_sh  <= {8'h00, a_sh[W-1:8]};
                        b_sh  <= {8'h00, b_sh[W-1:8]};
                        carry <= add_cout;
                        cnt   <= cnt + 1'b1;
                        if (last) begin
                            cout <= add_cout;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bk_serial_add_ctrl.sv
module tb_bk_serial_add_ctrl;
    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin;
`ifdef BK_SUB_EN
    logic         sub;
`endif
    logic         abort;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    bk_serial_add_ctrl #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef BK_SUB_EN
        .sub       (sub),
`endif
        .abort     (abort),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one operation at the falling edge; accept happens on the next rising edge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic tc, input logic ts);
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        a        = ta;
        b        = tb;
        cin      = tc;
`ifdef BK_SUB_EN
        sub      = ts;
`else
        if (ts) $display("note: sub requested without BK_SUB_EN");
`endif
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        // Operand changes after the accepting edge must be ignored
        a   = 32'hDEAD_BEEF;
        b   = 32'hCAFE_F00D;
        cin = ~tc;
        check("busy_after_accept", 64'(busy), 64'd1);
        check("in_ready_run", 64'(in_ready), 64'd0);
    endtask

    // Full operation: latency, result, optional back-pressure, handshake.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic ts,
                          input logic [W-1:0] es, input logic ec, input int hold);
        int lat;
        out_ready = (hold == 0);
        start_op(ta, tb, tc, ts);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(NB));
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_sum"}, 64'(sum), 64'(es));
            check({tag, "_hold_cout"}, 64'(cout), 64'(ec));
            check({tag, "_hold_flags"}, {61'd0, out_valid, in_ready, busy}, 64'b101);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_released"}, {61'd0, out_valid, in_ready, busy}, 64'b010);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef BK_SUB_EN
        sub       = 1'b0;
`endif
        abort     = 1'b0;
        out_ready = 1'b1;

        #12;
        check("rst_flags", {61'd0, out_valid, in_ready, busy}, 64'b000);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        run_op("byte_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 0);
        run_op("full_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 0);
        run_op("alt_cin", 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 0);
        run_op("zero_cin", 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 0);
        run_op("backpressure", 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 5);
        run_op("msb_carry", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 0);
        run_op("max_nocarry", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("mixed", 32'h1357_9BDF, 32'h0246_8ACE, 1'b0, 1'b0, 32'h159E_26AD, 1'b0, 2);

        // Reset after two RUN edges wipes everything, including partial sum bytes
        start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_flags", {61'd0, out_valid, in_ready, busy}, 64'b000);
        check("midrun_rst_sum", 64'(sum), 64'd0);
        check("midrun_rst_cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 0);

        // Abort in IDLE blocks acceptance
        @(negedge clk);
        a = 32'h1; b = 32'h1; in_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0;
        check("abort_idle_busy", 64'(busy), 64'd0);

        // Abort in RUN
        start_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_run_flags", {61'd0, out_valid, in_ready, busy}, 64'b010);

        // Abort in DONE wins over out_ready
        out_ready = 1'b0;
        start_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check("abort_done_reached", 64'(out_valid), 64'd1);
        check("abort_done_sum", 64'(sum), 64'h30);
        abort = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_done_flags", {61'd0, out_valid, in_ready, busy}, 64'b010);

`ifdef BK_SUB_EN
        run_op("sub_pos", 32'h0000_0010, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_000F, 1'b1, 0);
        run_op("sub_neg", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("sub_off", 32'h0000_0010, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0012, 1'b0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
